// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard unit and its multiply/divide scoreboard.
package hazard_pkg;

  localparam int FWD_REGFILE    = 0;
  localparam int FWD_STAGE_BASE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_scoreboard.sv
// Tracks the in-flight multi-cycle mult/div so HI/LO consumers can be held in decode.
//
// state | meaning
// IDLE  | no mult/div in flight
// BUSY  | counting down, HI/LO not yet valid
// DONE  | HI/LO valid this cycle, one-cycle done pulse
module muldiv_scoreboard
  import hazard_pkg::*;
#(
  parameter int MULDIV_LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic busy_o,
  output logic done_o
);

  localparam int CNT_W = ($clog2(MULDIV_LATENCY) > 6) ? $clog2(MULDIV_LATENCY) : 6;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MULDIV_LATENCY - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start in any state reloads; decode stalls normally keep it out of BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      state_d = BUSY;
      cnt_d   = RELOAD;
    end else begin
      unique case (state_q)
        IDLE: cnt_d = '0;
        BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q == BUSY);
    done_o = (state_q == DONE);
  end

endmodule

// File: rtl/hazard_unit_param.sv
// Pipeline hazard unit: priority forwarding from N post-execute stages, load/branch
// stalls and a multiply/divide scoreboard stall for HI/LO consumers.
module hazard_unit_param
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int MULDIV_LATENCY = 32,
  localparam int FWD_SEL_W     = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               branch_decode,
  input  logic                               muldiv_decode,
  input  logic [REG_ADDR_W-1:0]              rs_decode,
  input  logic [REG_ADDR_W-1:0]              rt_decode,
  input  logic [REG_ADDR_W-1:0]              rs_execute,
  input  logic [REG_ADDR_W-1:0]              rt_execute,
  input  logic [REG_ADDR_W-1:0]              write_register_execute,
  input  logic                               register_write_execute,
  input  logic                               memory_to_register_execute,
  input  logic                               muldiv_start_execute,
  input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] write_register_stage,
  input  logic [NUM_FWD_STAGES-1:0]          register_write_stage,
  input  logic [NUM_FWD_STAGES-1:0]          memory_to_register_stage,
  input  logic                               jump_memory,
  output logic                               stall_fetch,
  output logic                               stall_decode,
  output logic                               flush_execute,
  output logic                               forward_a_decode,
  output logic                               forward_b_decode,
  output logic [FWD_SEL_W-1:0]               forward_a_execute,
  output logic [FWD_SEL_W-1:0]               forward_b_execute,
  output logic                               muldiv_busy,
  output logic                               muldiv_done
);

  logic [REG_ADDR_W-1:0] wr_stage [NUM_FWD_STAGES];
  logic load_stall, branch_stall, muldiv_stall, any_stall;
  logic ex_hits_decode, mem_hits_decode;
  logic unused_mem_to_reg_upper;

  // Only the memory stage's load flag matters; older stages have their data.
  assign unused_mem_to_reg_upper = ^memory_to_register_stage[NUM_FWD_STAGES-1:1];

  always_comb begin
    for (int i = 0; i < NUM_FWD_STAGES; i++) begin
      wr_stage[i] = write_register_stage[i*REG_ADDR_W +: REG_ADDR_W];
    end
  end

  // Walk oldest to youngest so the lowest-index (youngest) match is written last.
  always_comb begin
    forward_a_execute = FWD_SEL_W'(FWD_REGFILE);
    forward_b_execute = FWD_SEL_W'(FWD_REGFILE);
    for (int i = NUM_FWD_STAGES - 1; i >= 0; i--) begin
      if (register_write_stage[i] && (rs_execute != '0) && (wr_stage[i] == rs_execute))
        forward_a_execute = FWD_SEL_W'(FWD_STAGE_BASE + i);
      if (register_write_stage[i] && (rt_execute != '0) && (wr_stage[i] == rt_execute))
        forward_b_execute = FWD_SEL_W'(FWD_STAGE_BASE + i);
    end
  end

  always_comb begin
    forward_a_decode = register_write_stage[0] && !memory_to_register_stage[0] &&
                       (rs_decode != '0) && (wr_stage[0] == rs_decode);
    forward_b_decode = register_write_stage[0] && !memory_to_register_stage[0] &&
                       (rt_decode != '0) && (wr_stage[0] == rt_decode);
  end

  always_comb begin
    ex_hits_decode  = (write_register_execute != '0) &&
                      ((write_register_execute == rs_decode) ||
                       (write_register_execute == rt_decode));
    mem_hits_decode = (wr_stage[0] != '0) &&
                      ((wr_stage[0] == rs_decode) || (wr_stage[0] == rt_decode));
    load_stall      = memory_to_register_execute && register_write_execute && ex_hits_decode;
    branch_stall    = branch_decode &&
                      ((register_write_execute && ex_hits_decode) ||
                       (memory_to_register_stage[0] && mem_hits_decode));
    muldiv_stall    = muldiv_decode && (muldiv_busy || muldiv_start_execute);
    any_stall       = load_stall || branch_stall || muldiv_stall;
    stall_fetch     = any_stall;
    stall_decode    = any_stall;
    flush_execute   = any_stall || jump_memory;
  end

  muldiv_scoreboard #(
    .MULDIV_LATENCY(MULDIV_LATENCY)
  ) u_muldiv_scoreboard (
    .clk    (clk),
    .reset  (reset),
    .start_i(muldiv_start_execute),
    .busy_o (muldiv_busy),
    .done_o (muldiv_done)
  );

endmodule

// File: tb/tb_hazard_unit_param.sv
// Scoreboard bench: each driven cycle pushes hand-derived expected outputs, the
// falling-edge monitor pops and compares them.
module tb_hazard_unit_param;

  localparam int RW = 5;
  localparam int NS = 2;
  localparam int LAT = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset;
  logic branch_decode, muldiv_decode;
  logic [RW-1:0] rs_decode, rt_decode, rs_execute, rt_execute, write_register_execute;
  logic register_write_execute, memory_to_register_execute, muldiv_start_execute;
  logic [NS*RW-1:0] write_register_stage;
  logic [NS-1:0] register_write_stage, memory_to_register_stage;
  logic jump_memory;
  logic stall_fetch, stall_decode, flush_execute, forward_a_decode, forward_b_decode;
  logic [SW-1:0] forward_a_execute, forward_b_execute;
  logic muldiv_busy, muldiv_done;

  typedef struct {
    int id;
    int stall, flush, fad, fbd, fae, fbe, busy, done;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   step    = 0;

  always #5 clk = ~clk;

  hazard_unit_param #(
    .REG_ADDR_W(RW), .NUM_FWD_STAGES(NS), .MULDIV_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .branch_decode(branch_decode), .muldiv_decode(muldiv_decode),
    .rs_decode(rs_decode), .rt_decode(rt_decode),
    .rs_execute(rs_execute), .rt_execute(rt_execute),
    .write_register_execute(write_register_execute),
    .register_write_execute(register_write_execute),
    .memory_to_register_execute(memory_to_register_execute),
    .muldiv_start_execute(muldiv_start_execute),
    .write_register_stage(write_register_stage),
    .register_write_stage(register_write_stage),
    .memory_to_register_stage(memory_to_register_stage),
    .jump_memory(jump_memory),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_execute(flush_execute),
    .forward_a_decode(forward_a_decode), .forward_b_decode(forward_b_decode),
    .forward_a_execute(forward_a_execute), .forward_b_execute(forward_b_execute),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
  );

  task automatic chk(input string tag, input int obs, input int want);
    n_total++;
    if (obs != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, want);
    end
  endtask

  task automatic clr();
    branch_decode = 0; muldiv_decode = 0;
    rs_decode = '0; rt_decode = '0; rs_execute = '0; rt_execute = '0;
    write_register_execute = '0; register_write_execute = 0;
    memory_to_register_execute = 0; muldiv_start_execute = 0;
    write_register_stage = '0; register_write_stage = '0;
    memory_to_register_stage = '0; jump_memory = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input int stall, input int flush, input int fad, input int fbd,
                          input int fae, input int fbe, input int busy, input int done);
    exp_t e;
    step++;
    e.id = step; e.stall = stall; e.flush = flush; e.fad = fad; e.fbd = fbd;
    e.fae = fae; e.fbe = fbe; e.busy = busy; e.done = done;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("s%0d stall_fetch", e.id), int'(stall_fetch), e.stall);
      chk($sformatf("s%0d stall_decode", e.id), int'(stall_decode), e.stall);
      chk($sformatf("s%0d flush_execute", e.id), int'(flush_execute), e.flush);
      chk($sformatf("s%0d fwd_a_dec", e.id), int'(forward_a_decode), e.fad);
      chk($sformatf("s%0d fwd_b_dec", e.id), int'(forward_b_decode), e.fbd);
      chk($sformatf("s%0d fwd_a_ex", e.id), int'(forward_a_execute), e.fae);
      chk($sformatf("s%0d fwd_b_ex", e.id), int'(forward_b_execute), e.fbe);
      chk($sformatf("s%0d busy", e.id), int'(muldiv_busy), e.busy);
      chk($sformatf("s%0d done", e.id), int'(muldiv_done), e.done);
    end
  end

  initial begin
    reset = 1'b1;
    clr();
    cyc(); expect_o(0,0,0,0,0,0,0,0);
    cyc(); reset = 1'b0; expect_o(0,0,0,0,0,0,0,0);

    // execute forwarding priority
    cyc(); clr(); write_register_stage = {5'd5, 5'd5}; register_write_stage = 2'b11;
    rs_execute = 5'd5; expect_o(0,0,0,0,1,0,0,0);
    cyc(); register_write_stage = 2'b10; expect_o(0,0,0,0,2,0,0,0);
    cyc(); clr(); register_write_stage = 2'b11; rs_execute = 5'd0;
    expect_o(0,0,0,0,0,0,0,0);
    cyc(); clr(); write_register_stage = {5'd5, 5'd3}; register_write_stage = 2'b11;
    rs_execute = 5'd3; rt_execute = 5'd5; expect_o(0,0,0,0,1,2,0,0);

    // load-use stall, then released
    cyc(); clr(); memory_to_register_execute = 1; register_write_execute = 1;
    write_register_execute = 5'd7; rt_decode = 5'd7; expect_o(1,1,0,0,0,0,0,0);
    cyc(); clr(); expect_o(0,0,0,0,0,0,0,0);
    cyc(); clr(); memory_to_register_execute = 1; register_write_execute = 1;
    write_register_execute = 5'd0; rt_decode = 5'd0; expect_o(0,0,0,0,0,0,0,0);

    // branch hazards
    cyc(); clr(); branch_decode = 1; register_write_execute = 1;
    write_register_execute = 5'd3; rs_decode = 5'd3; expect_o(1,1,0,0,0,0,0,0);
    cyc(); clr(); branch_decode = 1; rs_decode = 5'd3;
    write_register_stage = {5'd0, 5'd3}; register_write_stage = 2'b01;
    expect_o(0,0,1,0,0,0,0,0);
    cyc(); memory_to_register_stage = 2'b01; expect_o(1,1,0,0,0,0,0,0);

    // jump alone
    cyc(); clr(); jump_memory = 1; expect_o(0,1,0,0,0,0,0,0);

    // muldiv with HI/LO consumer held in decode, jump mid-flight
    cyc(); clr(); muldiv_start_execute = 1; muldiv_decode = 1; expect_o(1,1,0,0,0,0,0,0);
    cyc(); muldiv_start_execute = 0; expect_o(1,1,0,0,0,0,1,0);
    cyc(); jump_memory = 1; expect_o(1,1,0,0,0,0,1,0);
    cyc(); jump_memory = 0; expect_o(1,1,0,0,0,0,1,0);
    cyc(); expect_o(0,0,0,0,0,0,0,1);
    cyc(); expect_o(0,0,0,0,0,0,0,0);

    // reset with cnt = 2: no done pulse afterwards
    cyc(); clr(); muldiv_start_execute = 1; muldiv_decode = 1; expect_o(1,1,0,0,0,0,0,0);
    cyc(); muldiv_start_execute = 0; expect_o(1,1,0,0,0,0,1,0);
    cyc(); reset = 1'b1; expect_o(0,0,0,0,0,0,0,0);
    cyc(); reset = 1'b0; expect_o(0,0,0,0,0,0,0,0);
    cyc(); expect_o(0,0,0,0,0,0,0,0);
    cyc(); expect_o(0,0,0,0,0,0,0,0);

    // back-to-back issue from DONE reloads the counter
    cyc(); clr(); muldiv_start_execute = 1; expect_o(0,0,0,0,0,0,0,0);
    cyc(); muldiv_start_execute = 0; expect_o(0,0,0,0,0,0,1,0);
    cyc(); expect_o(0,0,0,0,0,0,1,0);
    cyc(); expect_o(0,0,0,0,0,0,1,0);
    cyc(); muldiv_start_execute = 1; expect_o(0,0,0,0,0,0,0,1);
    cyc(); muldiv_start_execute = 0; expect_o(0,0,0,0,0,0,1,0);
    cyc(); expect_o(0,0,0,0,0,0,1,0);
    cyc(); expect_o(0,0,0,0,0,0,1,0);
    cyc(); expect_o(0,0,0,0,0,0,0,1);
    cyc(); expect_o(0,0,0,0,0,0,0,0);

    cyc(); clr();
    cyc();
    cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
